dsd_debug_ctrl: RTL
===================

# dsd_debug_ctrl

Capture sequencer for the filter's debug memories. Watches the filter output stream (`valid_o` / `data_o`) and generates the shared `W` and `R` strobes that drive both `dsd_debug_memory` instances (data and valid). A host arms it, it captures a fixed-length window after a trigger, and it then streams the window back out on request. It sits beside `avg_filter` and replaces the free-running `W` / `R` inputs with a controlled arm/trigger/dump sequence.

## Interface

Parameters:

- `DATA_WIDTH`, 32, width of the monitored filter output.
- `MEMORY_DEPTH`, 16, number of entries in each debug memory. Power of two, ≥ 2.

Ports (one clock; reset is synchronous and active-low):

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `arm_i`  in  1  one-cycle pulse that arms the trigger.
- `abort_i`  in  1  one-cycle pulse that returns to IDLE from any state.
- `dump_i`  in  1  one-cycle pulse that starts readout of a full capture.
- `trig_mode_i`  in  1  0 = trigger on valid only; 1 = trigger on valid and data threshold.
- `threshold_i`  in  DATA_WIDTH  unsigned trigger threshold.
- `mon_valid_i`  in  1  filter `valid_o`.
- `mon_data_i`  in  DATA_WIDTH  filter `data_o`.
- `rd_ready_i`  in  1  readout consumer ready.
- `W`  out  1  debug memory write strobe, registered.
- `R`  out  1  debug memory read strobe.
- `rd_valid_o`  out  1  debug memory output valid this cycle.
- `rd_last_o`  out  1  qualifies the final readout entry.
- `done_o`  out  1  capture complete, data held.
- `busy_o`  out  1  state is not IDLE.
- `state_o`  out  3  0 IDLE, 1 ARMED, 2 CAPTURE, 3 FULL, 4 READOUT.
- `cap_count_o`  out  $clog2(MEMORY_DEPTH)+1  entries written in the current capture.

## Operation

- Debug memory contract:
  - While `W`=1, the memory stores its input and advances its write pointer every clock.
  - Each cycle with `R`=1, the memory presents the next stored entry on its output one clock later, oldest entry first.
- IDLE: `W`=`R`=0. `arm_i` → ARMED.
- ARMED: trigger fires when `mon_valid_i`=1 and (`trig_mode_i`=0 or `mon_data_i` ≥ `threshold_i`).
  - Comparison is unsigned, full DATA_WIDTH.
  - On trigger → CAPTURE; the counter loads MEMORY_DEPTH.
- CAPTURE:
  - `W`=1 for exactly MEMORY_DEPTH consecutive cycles, independent of `mon_valid_i`.
  - `cap_count_o` increments once per `W` cycle.
  - After the last write → FULL.
- FULL:
  - `done_o`=1.
  - `dump_i` → READOUT.
  - `arm_i` → ARMED; the held capture is discarded and `cap_count_o` clears to 0.
- READOUT:
  - `R` = (state==READOUT) and `rd_ready_i`. `R` is combinational from the registered state.
  - The entry counter decrements on each `R` cycle.
  - `rd_valid_o` = `R` delayed by one register stage.
  - `rd_last_o` = 1 with the `rd_valid_o` that belongs to the MEMORY_DEPTH-th `R`.
  - After the MEMORY_DEPTH-th `R` → IDLE. The trailing `rd_valid_o`/`rd_last_o` is still emitted the cycle after entering IDLE.
- `abort_i` in any state → IDLE next cycle: `W`, `R` and `done_o` deassert and counters clear. A `rd_valid_o` already in flight still emits.
- Priority when pulses coincide: `abort_i` > `arm_i` > `dump_i`.
- Pulses with no transition defined for the current state are ignored:
  - `arm_i` in ARMED, CAPTURE or READOUT.
  - `dump_i` in any state except FULL.
- `busy_o`=1 in every state except IDLE.

## Timing

- Reset (`rst_n`=0 at a clock edge) forces the following on the next cycle, including mid-capture or mid-readout, with no partial-sequence continuation: state IDLE, `W`=0, `R`=0, `rd_valid_o`=0, `rd_last_o`=0, `done_o`=0, `busy_o`=0, `cap_count_o`=0.
- Arm latency: `arm_i` at cycle t → `state_o`=1 at t+1.
- Trigger latency: trigger condition at cycle t → `W`=1 for cycles t+1 … t+MEMORY_DEPTH.
  - The triggering sample itself is not captured.
  - `done_o`=1 from t+MEMORY_DEPTH+1.
- Readout latency:
  - `dump_i` at t → first possible `R` at t+1 → `rd_valid_o` at t+2.
  - With `rd_ready_i` held high, readout is back-to-back and `rd_last_o` occurs at t+MEMORY_DEPTH+1.
- Backpressure: `rd_ready_i`=0 suppresses `R` in that same cycle. `rd_ready_i` does not stall a `rd_valid_o` already issued; the consumer must accept it.
- `cap_count_o` saturates at MEMORY_DEPTH and holds through FULL and READOUT.

## Test plan

- Reset then `arm_i`, mode 0, first `mon_valid_i` at cycle 10 → `W` high for cycles 11–26 (16 cycles), `done_o` rises at 27, `cap_count_o`=16.
- Mode 1, `threshold_i`=100, valid samples 50, 99, 100 → trigger only on 100; no trigger on 99. Repeat with 0xFFFFFFFF vs threshold 1 → trigger (unsigned compare).
- Full capture then `dump_i` with `rd_ready_i`=1 → 16 `R` cycles, 16 `rd_valid_o` cycles lagging `R` by one cycle, `rd_last_o` only on the 16th; `state_o` returns to 0.
- Readout with `rd_ready_i` toggling 1,0,0,1… → `R` only on ready cycles, exactly 16 total, `rd_last_o` follows the 16th `R`.
- `rst_n` low during CAPTURE at count 7 → all outputs 0 next cycle, `cap_count_o`=0, no further `W`. Repeat with `abort_i` during READOUT → `R` drops next cycle, state IDLE.
- `arm_i` and `abort_i` in the same cycle from IDLE → stays IDLE. `arm_i` in FULL → ARMED, `done_o`=0, `cap_count_o`=0. `dump_i` in ARMED → ignored.

Source files
------------

// File: rtl/dsd_debug_ctrl.sv
// Capture sequencer for the filter debug memories: arm, trigger on the output
// stream, write a fixed-length window, then stream it back on request.
module dsd_debug_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            arm_i,
    input  logic                            abort_i,
    input  logic                            dump_i,
    input  logic                            trig_mode_i,
    input  logic [DATA_WIDTH-1:0]           threshold_i,
    input  logic                            mon_valid_i,
    input  logic [DATA_WIDTH-1:0]           mon_data_i,
    input  logic                            rd_ready_i,
    output logic                            W,
    output logic                            R,
    output logic                            rd_valid_o,
    output logic                            rd_last_o,
    output logic                            done_o,
    output logic                            busy_o,
    output logic [2:0]                      state_o,
    output logic [$clog2(MEMORY_DEPTH):0]   cap_count_o
);

    localparam int CW = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH = CW'(MEMORY_DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_FULL    = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] ent_cnt;
    logic [CW-1:0] cap_cnt;
    logic          w_q;
    logic          done_q;
    logic          rd_valid_q;
    logic          rd_last_q;
    logic          trig_hit;
    logic          rd_fire;

    assign trig_hit = mon_valid_i && (!trig_mode_i || (mon_data_i >= threshold_i));

    // Readout handshake: a read is issued in any READOUT cycle where the consumer
    // is ready; its data is valid one cycle later and cannot be stalled.
    assign rd_fire = (state == S_READOUT) && rd_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ent_cnt    <= '0;
            cap_cnt    <= '0;
            w_q        <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_last_q  <= rd_fire && (ent_cnt == ONE);
            if (abort_i) begin
                state   <= S_IDLE;
                ent_cnt <= '0;
                cap_cnt <= '0;
                w_q     <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm_i) begin
                            state   <= S_ARMED;
                            cap_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (trig_hit) begin
                            state   <= S_CAPTURE;
                            ent_cnt <= DEPTH;
                            cap_cnt <= '0;
                            w_q     <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        // One write per cycle regardless of mon_valid_i.
                        cap_cnt <= cap_cnt + ONE;
                        ent_cnt <= ent_cnt - ONE;
                        if (ent_cnt == ONE) begin
                            state  <= S_FULL;
                            w_q    <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    S_FULL: begin
                        if (arm_i) begin
                            state   <= S_ARMED;
                            cap_cnt <= '0;
                            done_q  <= 1'b0;
                        end else if (dump_i) begin
                            state   <= S_READOUT;
                            ent_cnt <= DEPTH;
                            done_q  <= 1'b0;
                        end
                    end
                    S_READOUT: begin
                        if (rd_fire) begin
                            ent_cnt <= ent_cnt - ONE;
                            if (ent_cnt == ONE) begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign W           = w_q;
    assign R           = rd_fire;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign done_o      = done_q;
    assign busy_o      = (state != S_IDLE);
    assign state_o     = state;
    assign cap_count_o = cap_cnt;

endmodule
